// File: rtl/tcam_pkg.sv
// Shared types for the TCAM lookup engine: command opcodes and controller states.
package tcam_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_LOOKUP = 2'd2,
    OP_FLUSH  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD     = 3'd2,
    S_CMP    = 3'd3,
    S_CMP_RD = 3'd4,
    S_FLU    = 3'd5,
    S_RSP    = 3'd6
  } state_e;

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational priority encoder over the registered match vector; lowest index wins.
module tcam_prio_enc #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic [WORDS-1:0]  match,
  output logic              hit,
  output logic              multi,
  output logic [ADDR_W-1:0] idx
);

  always_comb begin
    idx = '0;
    // Walk downwards so the last assignment is the lowest set bit.
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (match[i]) idx = ADDR_W'(i);
    end
  end

  assign hit   = |match;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(match & (match - WORDS'(1)));

endmodule

// File: rtl/tcam_lookup_engine.sv
// Ternary CAM with write/read/lookup/flush behind valid/ready command and response ports.
// Lookups run a registered compare stage followed by a priority-encode-and-read stage.
module tcam_lookup_engine
  import tcam_pkg::*;
#(
  parameter int KEY_W  = 4,
  parameter int RES_W  = 4,
  parameter int WORDS  = 16,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic [KEY_W-1:0]  cmd_mask,
  input  logic [RES_W-1:0]  cmd_result,
  input  logic              cmd_vld,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic              rsp_hit,
  output logic              rsp_multi,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [KEY_W-1:0]  rsp_key,
  output logic [KEY_W-1:0]  rsp_mask,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_entry_vld
);

  state_e              state;
  op_e                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [KEY_W-1:0]    key_q;
  logic [KEY_W-1:0]    mask_q;
  logic [RES_W-1:0]    res_q;
  logic                vld_in_q;
  logic [WORDS-1:0]    mvec_q;

  logic [WORDS-1:0]    vld;
  logic [KEY_W-1:0]    ekey  [WORDS];
  logic [KEY_W-1:0]    emask [WORDS];
  logic [RES_W-1:0]    eres  [WORDS];

  logic                pe_hit;
  logic                pe_multi;
  logic [ADDR_W-1:0]   pe_idx;
  logic                in_range;

  assign in_range  = ({1'b0, addr_q} < (ADDR_W + 1)'(WORDS));
  assign cmd_ready = (state == S_IDLE) && !rst;

  tcam_prio_enc #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .match (mvec_q),
    .hit   (pe_hit),
    .multi (pe_multi),
    .idx   (pe_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      op_q          <= OP_WRITE;
      addr_q        <= '0;
      key_q         <= '0;
      mask_q        <= '0;
      res_q         <= '0;
      vld_in_q      <= 1'b0;
      mvec_q        <= '0;
      vld           <= '0;
      rsp_valid     <= 1'b0;
      rsp_op        <= '0;
      rsp_hit       <= 1'b0;
      rsp_multi     <= 1'b0;
      rsp_addr      <= '0;
      rsp_key       <= '0;
      rsp_mask      <= '0;
      rsp_result    <= '0;
      rsp_entry_vld <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        ekey[i]  <= '0;
        emask[i] <= '0;
        eres[i]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= op_e'(cmd_op);
            addr_q   <= cmd_addr;
            key_q    <= cmd_key;
            mask_q   <= cmd_mask;
            res_q    <= cmd_result;
            vld_in_q <= cmd_vld;
            case (op_e'(cmd_op))
              OP_WRITE:  state <= S_WR;
              OP_READ:   state <= S_RD;
              OP_LOOKUP: state <= S_CMP;
              default:   state <= S_FLU;
            endcase
          end
        end
        S_WR: begin
          // Out-of-range writes are dropped but still acknowledged.
          if (in_range) begin
            ekey[addr_q]  <= key_q;
            emask[addr_q] <= mask_q;
            eres[addr_q]  <= res_q;
            vld[addr_q]   <= vld_in_q;
          end
          rsp_op        <= op_q;
          rsp_hit       <= 1'b0;
          rsp_multi     <= 1'b0;
          rsp_addr      <= addr_q;
          rsp_key       <= '0;
          rsp_mask      <= '0;
          rsp_result    <= '0;
          rsp_entry_vld <= 1'b0;
          rsp_valid     <= 1'b1;
          state         <= S_RSP;
        end
        S_RD: begin
          rsp_op        <= op_q;
          rsp_hit       <= 1'b0;
          rsp_multi     <= 1'b0;
          rsp_addr      <= in_range ? addr_q : '0;
          rsp_key       <= in_range ? ekey[addr_q] : '0;
          rsp_mask      <= in_range ? emask[addr_q] : '0;
          rsp_result    <= in_range ? eres[addr_q] : '0;
          rsp_entry_vld <= in_range ? vld[addr_q] : 1'b0;
          rsp_valid     <= 1'b1;
          state         <= S_RSP;
        end
        S_CMP: begin
          for (int i = 0; i < WORDS; i++) begin
            mvec_q[i] <= vld[i] & (((key_q ^ ekey[i]) & emask[i] & mask_q) == '0);
          end
          state <= S_CMP_RD;
        end
        S_CMP_RD: begin
          rsp_op        <= op_q;
          rsp_hit       <= pe_hit;
          rsp_multi     <= pe_multi;
          rsp_addr      <= pe_hit ? pe_idx : '0;
          rsp_key       <= '0;
          rsp_mask      <= '0;
          rsp_result    <= pe_hit ? eres[pe_idx] : '0;
          rsp_entry_vld <= 1'b0;
          rsp_valid     <= 1'b1;
          state         <= S_RSP;
        end
        S_FLU: begin
          vld           <= '0;
          rsp_op        <= op_q;
          rsp_hit       <= 1'b0;
          rsp_multi     <= 1'b0;
          rsp_addr      <= '0;
          rsp_key       <= '0;
          rsp_mask      <= '0;
          rsp_result    <= '0;
          rsp_entry_vld <= 1'b0;
          rsp_valid     <= 1'b1;
          state         <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_lookup_engine.sv
// Bench for tcam_lookup_engine: directed scenarios then random commands against an array model.
module tb_tcam_lookup_engine;

  localparam int KEY_W  = 4;
  localparam int RES_W  = 4;
  localparam int WORDS  = 12;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [KEY_W-1:0]  cmd_key;
  logic [KEY_W-1:0]  cmd_mask;
  logic [RES_W-1:0]  cmd_result;
  logic              cmd_vld;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_op;
  logic              rsp_hit;
  logic              rsp_multi;
  logic [ADDR_W-1:0] rsp_addr;
  logic [KEY_W-1:0]  rsp_key;
  logic [KEY_W-1:0]  rsp_mask;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_entry_vld;

  int checks;
  int failures;

  logic [3:0] mk [WORDS];
  logic [3:0] mm [WORDS];
  logic [3:0] mr [WORDS];
  logic       mv [WORDS];

  tcam_lookup_engine #(
    .KEY_W  (KEY_W),
    .RES_W  (RES_W),
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_key       (cmd_key),
    .cmd_mask      (cmd_mask),
    .cmd_result    (cmd_result),
    .cmd_vld       (cmd_vld),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_op        (rsp_op),
    .rsp_hit       (rsp_hit),
    .rsp_multi     (rsp_multi),
    .rsp_addr      (rsp_addr),
    .rsp_key       (rsp_key),
    .rsp_mask      (rsp_mask),
    .rsp_result    (rsp_result),
    .rsp_entry_vld (rsp_entry_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < WORDS; i++) begin
      mk[i] = '0;
      mm[i] = '0;
      mr[i] = '0;
      mv[i] = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] k,
                         input logic [3:0] m, input logic [3:0] r, input logic v, input int hold);
    logic       e_hit, e_multi, e_evld, found;
    logic [3:0] e_addr, e_key, e_mask, e_res;
    logic [20:0] snap;
    int cnt, lat, n;
    e_hit = 0; e_multi = 0; e_evld = 0; e_addr = 0; e_key = 0; e_mask = 0; e_res = 0;
    case (op)
      2'd0: e_addr = a;
      2'd1: if (int'(a) < WORDS) begin
        e_addr = a; e_key = mk[a]; e_mask = mm[a]; e_res = mr[a]; e_evld = mv[a];
      end
      2'd2: begin
        cnt = 0; found = 0;
        for (int i = 0; i < WORDS; i++) begin
          if (mv[i] && (((k ^ mk[i]) & mm[i] & m) == 4'h0)) begin
            cnt++;
            if (!found) begin
              found = 1; e_addr = 4'(i); e_res = mr[i];
            end
          end
        end
        e_hit = (cnt >= 1);
        e_multi = (cnt >= 2);
      end
      default: ;
    endcase

    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_key = k; cmd_mask = m;
    cmd_result = r; cmd_vld = v;
    rsp_ready = (hold == 0);
    @(negedge clk);
    cmd_valid = 0;
    cmd_key = 4'($urandom); cmd_addr = 4'($urandom); cmd_mask = 4'($urandom);
    cmd_result = 4'($urandom); cmd_vld = 1'($urandom);
    chk("ready_busy", cmd_ready, 0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (op == 2'd2) ? 3 : 2);
    snap = {rsp_op, rsp_hit, rsp_multi, rsp_addr, rsp_key, rsp_mask, rsp_result, rsp_entry_vld};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_stable", {rsp_op, rsp_hit, rsp_multi, rsp_addr, rsp_key, rsp_mask,
                          rsp_result, rsp_entry_vld}, snap);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_valid", rsp_valid, 1);
    end
    chk("rsp_op", rsp_op, op);
    chk("rsp_hit", rsp_hit, e_hit);
    chk("rsp_multi", rsp_multi, e_multi);
    chk("rsp_addr", rsp_addr, e_addr);
    chk("rsp_key", rsp_key, e_key);
    chk("rsp_mask", rsp_mask, e_mask);
    chk("rsp_result", rsp_result, e_res);
    chk("rsp_entry_vld", rsp_entry_vld, e_evld);
    rsp_ready = 1;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);

    if (op == 2'd0 && int'(a) < WORDS) begin
      mk[a] = k; mm[a] = m; mr[a] = r; mv[a] = v;
    end
    if (op == 2'd3) begin
      for (int i = 0; i < WORDS; i++) mv[i] = 1'b0;
    end
  endtask

  initial begin
    int sel, hold;
    logic [1:0] op;
    checks = 0; failures = 0;
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_key = 0; cmd_mask = 0;
    cmd_result = 0; cmd_vld = 0; rsp_ready = 1;
    model_clear();

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_fields", {rsp_op, rsp_hit, rsp_multi, rsp_addr, rsp_key, rsp_mask,
                           rsp_result, rsp_entry_vld}, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    run_cmd(2'd1, 4'd3, 0, 0, 0, 0, 0);
    run_cmd(2'd0, 4'd5, 4'hA, 4'hF, 4'h7, 1, 0);
    run_cmd(2'd2, 4'd0, 4'hA, 4'hF, 4'h0, 0, 0);
    run_cmd(2'd0, 4'd2, 4'h8, 4'h8, 4'h1, 1, 0);
    run_cmd(2'd0, 4'd9, 4'hA, 4'hF, 4'h2, 1, 0);
    run_cmd(2'd2, 4'd0, 4'hA, 4'hF, 4'h0, 0, 0);
    run_cmd(2'd3, 4'd0, 0, 0, 0, 0, 0);
    run_cmd(2'd2, 4'd0, 4'hA, 4'hF, 4'h0, 0, 0);
    run_cmd(2'd1, 4'd9, 0, 0, 0, 0, 0);
    // Stored-invalid entry must never match even with a fully don't-care key.
    run_cmd(2'd0, 4'd4, 4'h3, 4'h0, 4'h6, 0, 0);
    run_cmd(2'd2, 4'd0, 4'h3, 4'h0, 4'h0, 0, 0);
    run_cmd(2'd0, 4'd7, 4'hC, 4'hF, 4'h5, 1, 0);
    run_cmd(2'd2, 4'd0, 4'hC, 4'hF, 4'h0, 0, 5);
    run_cmd(2'd0, 4'd11, 4'h1, 4'hF, 4'h9, 1, 0);
    run_cmd(2'd0, 4'd13, 4'h2, 4'hF, 4'h9, 1, 0);
    run_cmd(2'd1, 4'd13, 0, 0, 0, 0, 0);
    run_cmd(2'd1, 4'd11, 0, 0, 0, 0, 0);

    // Reset landing on the WR cycle must drop the write and its response.
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'd0; cmd_addr = 4'd1; cmd_key = 4'h3; cmd_mask = 4'hF;
    cmd_result = 4'h4; cmd_vld = 1;
    @(negedge clk);
    cmd_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    rst = 0;
    model_clear();
    #1;
    chk("midrst_ready_after", cmd_ready, 1);
    @(negedge clk);
    chk("midrst_no_rsp", rsp_valid, 0);
    run_cmd(2'd1, 4'd1, 0, 0, 0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      run_cmd(op, 4'($urandom_range(0, 15)), 4'($urandom), 
              (op == 2'd2 && $urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom),
              4'($urandom), ($urandom_range(0, 5) != 0), hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcam_lookup_engine.md
# tcam_lookup_engine

Self-contained, parametrised TCAM lookup engine: a behavioural ternary array with per-entry key, care-mask, result and valid bit, behind a valid/ready command port and a valid/ready response port. It supports write, read, lookup and flush. Lookups use a registered two-stage compare / priority-encode-and-read pipeline, report multi-hit, and resolve priority deterministically to the lowest index. It is the drop-in successor to the fixed 16x8 CAM controller used by the packet-routing datapath, with generic depth, key width and result width.

## Interface
- KEY_W, default 4: key and mask width.
- RES_W, default 4: result (destination ID) width.
- WORDS, default 16: number of entries, ≥2, power of two not required.
- ADDR_W, default $clog2(WORDS): entry address width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine accepts a command.
- cmd_op  in  2  0 WRITE, 1 READ, 2 LOOKUP, 3 FLUSH.
- cmd_addr  in  ADDR_W  entry index (WRITE/READ).
- cmd_key  in  KEY_W  entry key (WRITE) or search key (LOOKUP).
- cmd_mask  in  KEY_W  entry care-mask (WRITE) or global search mask (LOOKUP); 1 = compare bit.
- cmd_result  in  RES_W  entry result (WRITE).
- cmd_vld  in  1  entry valid bit to store (WRITE).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_op  out  2  op being answered.
- rsp_hit  out  1  LOOKUP matched ≥1 entry.
- rsp_multi  out  1  LOOKUP matched ≥2 entries.
- rsp_addr  out  ADDR_W  matched index (LOOKUP) or echoed address (READ/WRITE).
- rsp_key, rsp_mask  out  KEY_W  stored entry (READ).
- rsp_result  out  RES_W  stored/matched result (READ/LOOKUP).
- rsp_entry_vld  out  1  stored valid bit (READ).

## Operation
- FSM states: IDLE, WR, RD, CMP, CMP_RD, FLU, RSP.
- IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch command, go to WR/RD/CMP/FLU by cmd_op.
- WR: write key, mask, result and valid at cmd_addr. Load rsp_addr=addr; other rsp fields are 0. Go to RSP.
- RD: load rsp fields from entry cmd_addr. Go to RSP.
- CMP: register match vector. m[i] = vld[i] & (((key ^ ekey[i]) & emask[i] & smask) == 0). Go to CMP_RD.
- CMP_RD: priority-encode the registered vector, lowest index wins. Load rsp_hit, rsp_multi, rsp_addr and rsp_result=eres[addr]. Go to RSP.
- Miss: hit=0, multi=0, addr=0, result=0.
- FLU: clear every valid bit in one cycle; key/mask/result retained. Go to RSP.
- RSP: rsp_valid=1 with all rsp fields stable until rsp_valid&&rsp_ready, then go to IDLE.
- cmd_addr ≥ WORDS: WRITE is dropped but still acknowledged; READ returns all-zero fields.
- Entries not valid never match, whatever their key and mask.

## Timing
- Accept at edge T. rsp_valid rises after edge T+1 for WRITE/READ/FLUSH and after edge T+2 for LOOKUP.
- Array update for WRITE/FLUSH is visible to any command accepted after the response handshake.
- One command in flight; cmd_ready=0 from acceptance until the response handshake completes. Peak throughput is one op per 3 cycles (4 for LOOKUP) with rsp_ready tied high.
- rsp_ready held low: the engine stays in RSP indefinitely, outputs frozen.
- Reset, including mid-operation: FSM to IDLE and all valid bits cleared; in-flight command dropped with no response. A WRITE in its WR cycle is not committed if rst is high on that edge.
- Output values during and after reset: rsp_valid=0 and all rsp fields 0. cmd_ready=0 while rst is high and 1 in the first cycle after rst falls.

## Structure
- Package tcam_pkg: op enum (OP_WRITE..OP_FLUSH) and FSM state enum.
- Sub-module tcam_prio_enc: parameters WORDS and ADDR_W. Input is the match vector; outputs are hit, multi and the lowest-set index. It is purely combinational and used in CMP_RD.
- Array as flat registers (vld, ekey, emask, eres), not a macro.

## Test plan
- Reset, then READ addr 3 -> rsp_entry_vld=0, rsp_key=0, rsp_result=0; cmd_ready=1 the cycle after rst falls.
- WRITE addr 5 key=4'hA mask=4'hF res=4'h7 vld=1; LOOKUP key=4'hA smask=4'hF -> hit=1, multi=0, addr=5, result=7, rsp_valid two cycles after accept.
- Entries 2 (key 4'h8 mask 4'h8 res 1) and 9 (key 4'hA mask 4'hF res 2); LOOKUP 4'hA -> hit=1, multi=1, addr=2, result=1.
- FLUSH, then LOOKUP 4'hA -> hit=0, addr=0, result=0; READ addr 9 -> key=4'hA, entry_vld=0.
- LOOKUP with rsp_ready low for 5 cycles -> rsp fields stable and cmd_ready=0 throughout; handshake -> IDLE, next command accepted.
- Assert rst in the WR cycle of WRITE addr 1 -> no response; subsequent READ addr 1 -> entry_vld=0.
